// File: rtl/uart_cmd_parser.sv
// Purpose: parses 6-byte servo/config frames (FF AA ID AH AL CS) from a byte receiver.
// Latency: outputs and the cmd_valid/frame_err pulses appear 1 clk after the CS rx_done.
// Backpressure: none; bytes arrive as rx_done pulses and are always consumed. A stalled frame times out.
module uart_cmd_parser #(
   parameter int TIMEOUT_CYCLES = 500000,
   parameter int MAX_ID         = 5,
   parameter int ANGLE_MAX      = 2500
) (
   input  logic        clk,
   input  logic        reset_n,
   input  logic [7:0]  rx_data,
   input  logic        rx_done,
   output logic [2:0]  baud_set,
   output logic [7:0]  servo_id,
   output logic [15:0] servo_angle,
   output logic        cmd_valid,
   output logic        frame_err,
   output logic        busy
);

   localparam int              TW         = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
   localparam logic [TW-1:0]   TERM       = TW'(TIMEOUT_CYCLES - 1);
   localparam logic [7:0]      MAX_ID_B   = 8'(MAX_ID);
   localparam logic [15:0]     ANGLE_MAX_W = 16'(ANGLE_MAX);
   localparam logic [7:0]      CFG_ID     = 8'hF0;
   localparam logic [7:0]      BAUD_MAX   = 8'd4;
   localparam logic [7:0]      HDR1_B     = 8'hFF;
   localparam logic [7:0]      HDR2_B     = 8'hAA;

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      HDR2   = 3'd1,
      GET_ID = 3'd2,
      GET_AH = 3'd3,
      GET_AL = 3'd4,
      GET_CS = 3'd5
   } state_t;

   // Payload bytes captured while the frame is being received.
   typedef struct packed {
      logic [7:0] id;
      logic [7:0] ah;
      logic [7:0] al;
   } frame_t;

   state_t        state_q, state_d;
   logic [TW-1:0] timer_q, timer_d;
   frame_t        frm_q, frm_d;
   logic [7:0]    cs_q, cs_d;
   logic [2:0]    baud_q, baud_d;
   logic [7:0]    servo_id_q, servo_id_d;
   logic [15:0]   servo_angle_q, servo_angle_d;
   logic          cmd_valid_q, cmd_valid_d;
   logic          frame_err_q, frame_err_d;
   logic          busy_q, busy_d;

   logic          timeout;
   logic          is_cfg;
   logic          frame_bad;

   // A byte arriving on the terminal count wins over the timeout.
   assign timeout = (state_q != IDLE) && !rx_done && (timer_q == TERM);

   // Frame legality, evaluated against the CS byte currently on rx_data.
   assign is_cfg    = (frm_q.id == CFG_ID);
   assign frame_bad = (rx_data != cs_q) ||
                      (is_cfg  && (frm_q.al > BAUD_MAX)) ||
                      (!is_cfg && (frm_q.id > MAX_ID_B)) ||
                      (!is_cfg && ({frm_q.ah, frm_q.al} > ANGLE_MAX_W));

   // State register.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) state_q <= IDLE;
      else          state_q <= state_d;
   end

   // Next-state logic; once past the header, 0xFF is ordinary data.
   always_comb begin
      state_d = state_q;
      if (timeout) begin
         state_d = IDLE;
      end else if (rx_done) begin
         case (state_q)
            IDLE:    if (rx_data == HDR1_B) state_d = HDR2;
            HDR2:    if (rx_data == HDR2_B)      state_d = GET_ID;
                     else if (rx_data != HDR1_B) state_d = IDLE;
            GET_ID:  state_d = GET_AH;
            GET_AH:  state_d = GET_AL;
            GET_AL:  state_d = GET_CS;
            GET_CS:  state_d = IDLE;
            default: state_d = IDLE;
         endcase
      end
   end

   // Output and datapath next values: byte capture, checksum, timer, result pulses.
   always_comb begin
      timer_d       = (rx_done || (state_q == IDLE) || timeout) ? '0 : timer_q + TW'(1);
      frm_d         = frm_q;
      cs_d          = cs_q;
      baud_d        = baud_q;
      servo_id_d    = servo_id_q;
      servo_angle_d = servo_angle_q;
      cmd_valid_d   = 1'b0;
      frame_err_d   = 1'b0;
      busy_d        = (state_d != IDLE);
      if (timeout) begin
         frame_err_d = 1'b1;
      end else if (rx_done) begin
         case (state_q)
            HDR2:   if (rx_data == HDR2_B) cs_d = 8'h00;
            GET_ID: begin
               frm_d.id = rx_data;
               cs_d     = cs_q + rx_data;
            end
            GET_AH: begin
               frm_d.ah = rx_data;
               cs_d     = cs_q + rx_data;
            end
            GET_AL: begin
               frm_d.al = rx_data;
               cs_d     = cs_q + rx_data;
            end
            GET_CS: begin
               if (frame_bad) begin
                  frame_err_d = 1'b1;
               end else if (is_cfg) begin
                  baud_d = frm_q.al[2:0];
               end else begin
                  servo_id_d    = frm_q.id;
                  servo_angle_d = {frm_q.ah, frm_q.al};
                  cmd_valid_d   = 1'b1;
               end
            end
            default: ;
         endcase
      end
   end

   // Datapath and output registers.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         timer_q       <= '0;
         frm_q         <= '0;
         cs_q          <= 8'h00;
         baud_q        <= 3'd0;
         servo_id_q    <= 8'h00;
         servo_angle_q <= 16'h0000;
         cmd_valid_q   <= 1'b0;
         frame_err_q   <= 1'b0;
         busy_q        <= 1'b0;
      end else begin
         timer_q       <= timer_d;
         frm_q         <= frm_d;
         cs_q          <= cs_d;
         baud_q        <= baud_d;
         servo_id_q    <= servo_id_d;
         servo_angle_q <= servo_angle_d;
         cmd_valid_q   <= cmd_valid_d;
         frame_err_q   <= frame_err_d;
         busy_q        <= busy_d;
      end
   end

   assign baud_set    = baud_q;
   assign servo_id    = servo_id_q;
   assign servo_angle = servo_angle_q;
   assign cmd_valid   = cmd_valid_q;
   assign frame_err   = frame_err_q;
   assign busy        = busy_q;

endmodule

// File: tb/tb_uart_cmd_parser.sv
// Purpose: directed frame scenarios for uart_cmd_parser with hand-computed expectations.
// Latency: results are sampled on the falling edge right after the CS byte is clocked in.
// Backpressure: none; the bench paces bytes with fixed idle gaps.
module tb_uart_cmd_parser;

   localparam int T = 40;

   logic        clk = 1'b0;
   logic        reset_n;
   logic [7:0]  rx_data;
   logic        rx_done;
   logic [2:0]  baud_set;
   logic [7:0]  servo_id;
   logic [15:0] servo_angle;
   logic        cmd_valid;
   logic        frame_err;
   logic        busy;

   int n_cmp = 0;
   int n_bad = 0;
   int cmd_cnt = 0;
   int err_cnt = 0;
   int both_cnt = 0;

   uart_cmd_parser #(.TIMEOUT_CYCLES(T), .MAX_ID(5), .ANGLE_MAX(2500)) dut (
      .clk(clk), .reset_n(reset_n), .rx_data(rx_data), .rx_done(rx_done),
      .baud_set(baud_set), .servo_id(servo_id), .servo_angle(servo_angle),
      .cmd_valid(cmd_valid), .frame_err(frame_err), .busy(busy)
   );

   always #5 clk = ~clk;

   // Pulse counters: each high cycle is seen once at the edge that ends it.
   always @(posedge clk) begin
      if (cmd_valid) cmd_cnt++;
      if (frame_err) err_cnt++;
      if (cmd_valid && frame_err) both_cnt++;
   end

   // Called at a falling edge; returns at the falling edge after the byte was clocked in.
   task automatic send_byte(input logic [7:0] b);
      rx_data = b;
      rx_done = 1'b1;
      @(negedge clk);
      rx_done = 1'b0;
      rx_data = 8'h00;
   endtask

   task automatic idle(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic send_frame(input logic [47:0] f);
      for (int i = 0; i < 6; i++) begin
         send_byte(f[47-8*i -: 8]);
         if (i < 5) idle(2);
      end
   endtask

   task automatic test_reset;
      n_cmp++; if ({baud_set, servo_id, servo_angle, cmd_valid, frame_err, busy} !== 30'd0) begin
         n_bad++; $display("FAIL reset_outputs: got %h want 0", {baud_set, servo_id, servo_angle, cmd_valid, frame_err, busy}); end
      reset_n = 1'b1;
      idle(2);
      send_byte(8'hAA); idle(1); send_byte(8'h12);
      n_cmp++; if (busy !== 1'b0) begin
         n_bad++; $display("FAIL idle_junk_busy: got %b want 0", busy); end
   endtask

   task automatic test_valid;
      int c0, e0;
      c0 = cmd_cnt; e0 = err_cnt;
      idle(2);
      send_byte(8'hFF);
      n_cmp++; if (busy !== 1'b1) begin
         n_bad++; $display("FAIL valid_busy: got %b want 1", busy); end
      idle(2);
      send_byte(8'hAA); idle(2); send_byte(8'h02); idle(2);
      send_byte(8'h05); idle(2); send_byte(8'hDC); idle(2);
      send_byte(8'hE3);
      n_cmp++; if (cmd_valid !== 1'b1) begin
         n_bad++; $display("FAIL valid_cmd_latency: got %b want 1", cmd_valid); end
      n_cmp++; if (servo_id !== 8'h02) begin
         n_bad++; $display("FAIL valid_id: got %h want 02", servo_id); end
      n_cmp++; if (servo_angle !== 16'd1500) begin
         n_bad++; $display("FAIL valid_angle: got %0d want 1500", servo_angle); end
      n_cmp++; if (busy !== 1'b0) begin
         n_bad++; $display("FAIL valid_busy_end: got %b want 0", busy); end
      idle(1);
      n_cmp++; if (cmd_valid !== 1'b0) begin
         n_bad++; $display("FAIL valid_cmd_width: got %b want 0", cmd_valid); end
      n_cmp++; if ((cmd_cnt - c0) !== 1 || (err_cnt - e0) !== 0) begin
         n_bad++; $display("FAIL valid_counts: got cmd %0d err %0d want 1 0", cmd_cnt - c0, err_cnt - e0); end
   endtask

   task automatic test_config;
      int c0;
      c0 = cmd_cnt;
      idle(2);
      send_frame(48'hFFAAF00003F3);
      n_cmp++; if (baud_set !== 3'd3) begin
         n_bad++; $display("FAIL cfg_baud3: got %0d want 3", baud_set); end
      n_cmp++; if (cmd_valid !== 1'b0 || servo_id !== 8'h02 || servo_angle !== 16'd1500) begin
         n_bad++; $display("FAIL cfg_servo_hold: got cmd %b id %h ang %0d want 0 02 1500", cmd_valid, servo_id, servo_angle); end
      idle(2);
      send_frame(48'hFFAAF00007F7);
      n_cmp++; if (frame_err !== 1'b1 || baud_set !== 3'd3) begin
         n_bad++; $display("FAIL cfg_baud7_reject: got err %b baud %0d want 1 3", frame_err, baud_set); end
      idle(2);
      send_frame(48'hFFAAF00004F4);
      n_cmp++; if (frame_err !== 1'b0 || baud_set !== 3'd4) begin
         n_bad++; $display("FAIL cfg_baud4_accept: got err %b baud %0d want 0 4", frame_err, baud_set); end
      idle(2);
      send_frame(48'hFFAAF00005F5);
      n_cmp++; if (frame_err !== 1'b1 || baud_set !== 3'd4) begin
         n_bad++; $display("FAIL cfg_baud5_reject: got err %b baud %0d want 1 4", frame_err, baud_set); end
      idle(2);
      n_cmp++; if ((cmd_cnt - c0) !== 0) begin
         n_bad++; $display("FAIL cfg_no_cmd: got %0d pulses want 0", cmd_cnt - c0); end
   endtask

   task automatic test_reject;
      logic [47:0] tbl [3];
      tbl[0] = 48'hFFAA0205DC00;   // bad checksum
      tbl[1] = 48'hFFAA0209C5D0;   // angle 2501
      tbl[2] = 48'hFFAA0605DCE7;   // ID 6
      for (int k = 0; k < 3; k++) begin
         idle(2);
         send_frame(tbl[k]);
         n_cmp++; if (frame_err !== 1'b1 || cmd_valid !== 1'b0) begin
            n_bad++; $display("FAIL reject%0d_pulse: got err %b cmd %b want 1 0", k, frame_err, cmd_valid); end
         n_cmp++; if (servo_id !== 8'h02 || servo_angle !== 16'd1500 || baud_set !== 3'd4) begin
            n_bad++; $display("FAIL reject%0d_hold: got id %h ang %0d baud %0d want 02 1500 4", k, servo_id, servo_angle, baud_set); end
      end
      idle(2);
      send_frame(48'hFFAA0509C4D2);   // ID 5, angle 2500: both at the limit
      n_cmp++; if (cmd_valid !== 1'b1 || servo_id !== 8'h05 || servo_angle !== 16'd2500) begin
         n_bad++; $display("FAIL limit_accept: got cmd %b id %h ang %0d want 1 05 2500", cmd_valid, servo_id, servo_angle); end
   endtask

   task automatic test_resync;
      int e0;
      e0 = err_cnt;
      idle(2);
      send_byte(8'hFF); idle(2);
      send_frame(48'hFFAA01006465);
      n_cmp++; if (cmd_valid !== 1'b1 || servo_id !== 8'h01 || servo_angle !== 16'd100) begin
         n_bad++; $display("FAIL resync_ff: got cmd %b id %h ang %0d want 1 01 100", cmd_valid, servo_id, servo_angle); end
      idle(2);
      send_frame(48'hFFAA0300FF02);   // 0xFF inside the payload
      n_cmp++; if (cmd_valid !== 1'b1 || servo_id !== 8'h03 || servo_angle !== 16'd255) begin
         n_bad++; $display("FAIL ff_as_data: got cmd %b id %h ang %0d want 1 03 255", cmd_valid, servo_id, servo_angle); end
      idle(2);
      send_byte(8'hFF); idle(2); send_byte(8'h12); idle(2);
      send_frame(48'hFFAA01006465);
      n_cmp++; if (cmd_valid !== 1'b1 || servo_id !== 8'h01) begin
         n_bad++; $display("FAIL resync_junk: got cmd %b id %h want 1 01", cmd_valid, servo_id); end
      idle(2);
      n_cmp++; if ((err_cnt - e0) !== 0) begin
         n_bad++; $display("FAIL resync_no_err: got %0d pulses want 0", err_cnt - e0); end
   endtask

   task automatic test_timeout;
      int e0;
      e0 = err_cnt;
      idle(2);
      send_byte(8'hFF); idle(2); send_byte(8'hAA); idle(2); send_byte(8'h02);
      idle(T - 2);
      n_cmp++; if (busy !== 1'b1 || (err_cnt - e0) !== 0) begin
         n_bad++; $display("FAIL timeout_early: got busy %b err %0d want 1 0", busy, err_cnt - e0); end
      idle(6);
      n_cmp++; if (busy !== 1'b0 || (err_cnt - e0) !== 1) begin
         n_bad++; $display("FAIL timeout_fire: got busy %b err %0d want 0 1", busy, err_cnt - e0); end
      send_frame(48'hFFAA0205DCE3);
      n_cmp++; if (cmd_valid !== 1'b1 || servo_id !== 8'h02) begin
         n_bad++; $display("FAIL timeout_recover: got cmd %b id %h want 1 02", cmd_valid, servo_id); end
   endtask

   task automatic test_rx_priority;
      int e0;
      idle(2);
      e0 = err_cnt;
      send_byte(8'hFF); idle(2); send_byte(8'hAA); idle(2); send_byte(8'h04);
      idle(T - 1);                     // next byte lands on the terminal count
      send_byte(8'h01); idle(2); send_byte(8'h2C); idle(2); send_byte(8'h31);
      n_cmp++; if (cmd_valid !== 1'b1 || servo_id !== 8'h04 || servo_angle !== 16'd300) begin
         n_bad++; $display("FAIL rx_priority_cmd: got cmd %b id %h ang %0d want 1 04 300", cmd_valid, servo_id, servo_angle); end
      idle(2);
      n_cmp++; if ((err_cnt - e0) !== 0) begin
         n_bad++; $display("FAIL rx_priority_err: got %0d pulses want 0", err_cnt - e0); end
   endtask

   task automatic test_reset_midframe;
      int c0;
      idle(2);
      send_byte(8'hFF); idle(2); send_byte(8'hAA); idle(2);
      send_byte(8'h02); idle(2); send_byte(8'h05);
      n_cmp++; if (busy !== 1'b1) begin
         n_bad++; $display("FAIL midframe_busy: got %b want 1", busy); end
      #2 reset_n = 1'b0;
      #1;
      n_cmp++; if ({baud_set, servo_id, servo_angle, cmd_valid, frame_err, busy} !== 30'd0) begin
         n_bad++; $display("FAIL midframe_reset: got %h want 0", {baud_set, servo_id, servo_angle, cmd_valid, frame_err, busy}); end
      @(negedge clk);
      reset_n = 1'b1;
      idle(1);
      c0 = cmd_cnt;
      send_byte(8'hDC); idle(2); send_byte(8'hE3);
      idle(2);
      n_cmp++; if ((cmd_cnt - c0) !== 0 || servo_id !== 8'h00 || busy !== 1'b0) begin
         n_bad++; $display("FAIL midframe_discard: got cmd %0d id %h busy %b want 0 00 0", cmd_cnt - c0, servo_id, busy); end
      send_frame(48'hFFAA0205DCE3);
      n_cmp++; if (cmd_valid !== 1'b1 || servo_angle !== 16'd1500) begin
         n_bad++; $display("FAIL midframe_recover: got cmd %b ang %0d want 1 1500", cmd_valid, servo_angle); end
   endtask

   initial begin
      reset_n = 1'b0;
      rx_done = 1'b0;
      rx_data = 8'h00;
      repeat (3) @(negedge clk);
      test_reset;
      test_valid;
      test_config;
      test_reject;
      test_resync;
      test_timeout;
      test_rx_priority;
      test_reset_midframe;
      idle(2);
      n_cmp++; if (both_cnt !== 0) begin
         n_bad++; $display("FAIL err_cmd_overlap: got %0d cycles want 0", both_cnt); end
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
